// File: rtl/mega99_joy_pkg.sv
// Shared joystick vector width, bit positions and a counter-width helper
// for the Pmod joystick conditioning path.
package mega99_joy_pkg;

  localparam int JOY_W     = 5;
  localparam int JOY_FIRE  = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_RIGHT = 2;
  localparam int JOY_DOWN  = 3;
  localparam int JOY_UP    = 4;

  typedef logic [0:JOY_W-1] joy_vec_t;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/joy_debounce_bit.sv
// One joystick pin: 2-flop synchronizer followed by a tick-paced debouncer.
// The debounced value is kept active-low, matching the raw pin.
module joy_debounce_bit
  import mega99_joy_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pin_n,
  output logic debounced_n
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SAMPLES - 1);

  logic             meta_reg;
  logic             sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             deb_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      cnt_reg  <= '0;
      deb_reg  <= 1'b1;
    end else begin
      meta_reg <= pin_n;
      sync_reg <= meta_reg;
      // Any sample that agrees with the current state restarts the run.
      if (tick) begin
        if (sync_reg == deb_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          deb_reg <= sync_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign debounced_n = deb_reg;

endmodule

// File: rtl/joystick_conditioner.sv
// Conditions two active-low Pmod joysticks into debounced active-high vectors
// for the mainboard, with a shared sample prescaler and a change strobe.
module joystick_conditioner
  import mega99_joy_pkg::*;
#(
  parameter int PRESCALE         = 10740,
  parameter int DEBOUNCE_SAMPLES = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             joy_enable,
  input  logic [0:JOY_W-1] joy1_pin_n,
  input  logic [0:JOY_W-1] joy2_pin_n,
  output logic [0:JOY_W-1] joy1,
  output logic [0:JOY_W-1] joy2,
  output logic             joy_change
);

  localparam int               PRESC_W    = cnt_width(PRESCALE);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam int               NBITS      = 2 * JOY_W;

  logic [PRESC_W-1:0] presc_reg;
  logic               tick;

  logic [0:NBITS-1] pin_n_all;
  logic [0:NBITS-1] deb_n_all;

  joy_vec_t joy1_next;
  joy_vec_t joy2_next;
  joy_vec_t joy1_reg;
  joy_vec_t joy2_reg;
  logic     joy_change_reg;

  assign tick = (presc_reg == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PRESC_W'(1);
    end
  end

  // Joystick 1 occupies indices 0..4, joystick 2 indices 5..9.
  assign pin_n_all = {joy1_pin_n, joy2_pin_n};

  generate
    for (genvar gi = 0; gi < NBITS; gi++) begin : g_bit
      joy_debounce_bit #(
        .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
      ) u_bit (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .pin_n      (pin_n_all[gi]),
        .debounced_n(deb_n_all[gi])
      );
    end
  endgenerate

  assign joy1_next = ~deb_n_all[0:JOY_W-1]     & {JOY_W{joy_enable}};
  assign joy2_next = ~deb_n_all[JOY_W:NBITS-1] & {JOY_W{joy_enable}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      joy1_reg       <= '0;
      joy2_reg       <= '0;
      joy_change_reg <= 1'b0;
    end else begin
      joy1_reg       <= joy1_next;
      joy2_reg       <= joy2_next;
      joy_change_reg <= ({joy1_next, joy2_next} != {joy1_reg, joy2_reg});
    end
  end

  assign joy1       = joy1_reg;
  assign joy2       = joy2_reg;
  assign joy_change = joy_change_reg;

endmodule

// File: tb/tb_joystick_conditioner.sv
// Directed bench for joystick_conditioner with PRESCALE=4, DEBOUNCE_SAMPLES=3.
module tb_joystick_conditioner;

  localparam int PRESCALE = 4;
  localparam int DS       = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       joy_enable;
  logic [0:4] joy1_pin_n;
  logic [0:4] joy2_pin_n;
  logic [0:4] joy1;
  logic [0:4] joy2;
  logic       joy_change;

  int n_checks = 0;
  int n_fail   = 0;
  int chg_cnt  = 0;
  int cyc      = 0;
  int base;

  always #5 clk = ~clk;

  joystick_conditioner #(
    .PRESCALE        (PRESCALE),
    .DEBOUNCE_SAMPLES(DS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .joy_enable(joy_enable),
    .joy1_pin_n(joy1_pin_n),
    .joy2_pin_n(joy2_pin_n),
    .joy1      (joy1),
    .joy2      (joy2),
    .joy_change(joy_change)
  );

  // Cycles since the last edge that sampled reset; tick edges are multiples of PRESCALE.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (joy_change === 1'b1) chg_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic align_tick();
    do begin
      @(posedge clk);
      #1;
    end while (cyc % PRESCALE != 0);
  endtask

  function automatic logic [0:4] b(input int i);
    logic [0:4] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    joy_enable = 1'b1;
    joy1_pin_n = '0;
    joy2_pin_n = '0;
    step(3);
    check("rst_joy1", joy1, 5'd0);
    check("rst_joy2", joy2, 5'd0);
    check("rst_change", joy_change, 1'b0);

    // Pins held pressed through reset release: three full ticks, then output.
    rst_n = 1'b1;
    base  = chg_cnt;
    step(12);
    check("rel_early_joy1", joy1, 5'd0);
    step(1);
    check("rel_joy1", joy1, 5'b11111);
    check("rel_joy2", joy2, 5'b11111);
    step(5);
    check("rel_change_cnt", chg_cnt - base, 1);

    joy1_pin_n = '1;
    joy2_pin_n = '1;
    step(20);
    check("idle_joy1", joy1, 5'd0);
    check("idle_joy2", joy2, 5'd0);

    // Clean fire press on joystick 1.
    align_tick();
    base          = chg_cnt;
    joy1_pin_n[0] = 1'b0;
    step(12);
    check("press_early_joy1", joy1, 5'd0);
    step(1);
    check("press_joy1", joy1, b(0));
    check("press_joy2", joy2, 5'd0);
    step(5);
    check("press_change_cnt", chg_cnt - base, 1);

    // Two-tick glitch on joystick 2 up.
    align_tick();
    base          = chg_cnt;
    joy2_pin_n[4] = 1'b0;
    step(8);
    joy2_pin_n[4] = 1'b1;
    step(12);
    check("glitch_joy2", joy2, 5'd0);
    check("glitch_joy1", joy1, b(0));
    check("glitch_change_cnt", chg_cnt - base, 0);

    // Simultaneous edges on both joysticks.
    align_tick();
    base          = chg_cnt;
    joy1_pin_n[1] = 1'b0;
    joy2_pin_n[3] = 1'b0;
    step(12);
    check("simul_early_joy1", joy1, b(0));
    check("simul_early_joy2", joy2, 5'd0);
    step(1);
    check("simul_joy1", joy1, b(0) | b(1));
    check("simul_joy2", joy2, b(3));
    step(5);
    check("simul_change_cnt", chg_cnt - base, 1);

    // Release everything except joystick 1 right in one go.
    align_tick();
    base          = chg_cnt;
    joy1_pin_n    = '1;
    joy1_pin_n[2] = 1'b0;
    joy2_pin_n    = '1;
    step(13);
    check("swap_joy1", joy1, b(2));
    check("swap_joy2", joy2, 5'd0);
    step(5);
    check("swap_change_cnt", chg_cnt - base, 1);

    // Enable gating acts immediately, without re-debouncing.
    base       = chg_cnt;
    joy_enable = 1'b0;
    step(1);
    check("en_off_joy1", joy1, 5'd0);
    step(3);
    check("en_off_change_cnt", chg_cnt - base, 1);
    joy_enable = 1'b1;
    step(1);
    check("en_on_joy1", joy1, b(2));
    step(3);
    check("en_on_change_cnt", chg_cnt - base, 2);

    // Reset in the middle of a debounce run discards the partial count.
    align_tick();
    joy1_pin_n[0] = 1'b0;
    step(8);
    rst_n = 1'b0;
    step(1);
    check("midrst_joy1", joy1, 5'd0);
    check("midrst_joy2", joy2, 5'd0);
    check("midrst_change", joy_change, 1'b0);
    rst_n = 1'b1;
    base  = chg_cnt;
    step(12);
    check("midrst_early_joy1", joy1, 5'd0);
    step(1);
    check("midrst_joy1_after", joy1, b(0) | b(2));
    step(5);
    check("midrst_change_cnt", chg_cnt - base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/joystick_conditioner.md
JOYSTICK_CONDITIONER -- requirements
Module: joystick_conditioner

Interface
REQ-001 The module SHALL have parameter PRESCALE, default 10740, meaning the number of clk cycles per sample tick (about 10 kHz at the 107.4 MHz system clock).
REQ-002 The module SHALL have parameter DEBOUNCE_SAMPLES, default 50, meaning the number of consecutive differing samples (minimum 2) required before an output changes.
REQ-003 The module SHALL have port clk, input, 1 bit: the system clock; there is one clock.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port joy_enable, input, 1 bit: when low, joy1/joy2 are forced to 0.
REQ-006 The module SHALL have port joy1_pin_n, input, [0:4]: raw active-low Pmod joystick 1 pins, asynchronous.
REQ-007 The module SHALL have port joy2_pin_n, input, [0:4]: raw active-low Pmod joystick 2 pins, asynchronous.
REQ-008 The module SHALL have port joy1, output, [0:4]: debounced active-high joystick 1 state, feeding mainboard joy1.
REQ-009 The module SHALL have port joy2, output, [0:4]: debounced active-high joystick 2 state, feeding mainboard joy2.
REQ-010 The module SHALL have port joy_change, output, 1 bit: one-cycle pulse whenever any bit of joy1 or joy2 changes.
REQ-011 Bit order on all joystick vectors SHALL be [0]=fire, [1]=left, [2]=right, [3]=down, [4]=up.

Function
REQ-012 Each of the 10 pin inputs SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 A prescaler counter of width clog2(PRESCALE) SHALL count 0..PRESCALE-1 and wrap to 0.
REQ-014 The sample tick SHALL assert for exactly one cycle when the prescaler equals PRESCALE-1.
REQ-015 Per bit, on a tick, if sync value equals the debounced value, that bit's counter SHALL clear to 0.
REQ-016 Per bit, on a tick, if sync value differs and counter < DEBOUNCE_SAMPLES-1, the counter SHALL increment.
REQ-017 Per bit, on a tick, if sync value differs and counter = DEBOUNCE_SAMPLES-1, the debounced value SHALL take the sync value and the counter SHALL clear, on the same edge.
REQ-018 Between ticks, counters and debounced values SHALL hold.
REQ-019 A glitch shorter than DEBOUNCE_SAMPLES ticks SHALL never reach the outputs; any agreeing sample restarts the count.
REQ-020 joy1/joy2 SHALL be registered: the inverted debounced value ANDed with joy_enable, updated every cycle.
REQ-021 Latency from a stable pin edge to the output SHALL be 2 sync cycles plus DEBOUNCE_SAMPLES ticks (including the partial first tick) plus 1 output register cycle.
REQ-022 joy_change SHALL pulse the cycle after any registered output bit differs from its previous value; joy_enable toggling with any pressed bit counts as a change.
REQ-023 Simultaneous qualifying transitions on several bits SHALL update in the same cycle and produce a single joy_change pulse.
REQ-024 Opposing directions (left+right, up+down) SHALL be passed unmodified; there is no arbitration.

Reset
REQ-025 While rst_n=0 at a clk edge: synchronizer flops and debounced values SHALL be set to 1 (released); prescaler and all counters SHALL be 0; joy1, joy2 and joy_change SHALL be 0.
REQ-026 Reset asserted mid-count SHALL discard partial debounce progress.
REQ-027 After reset release, the first tick SHALL occur PRESCALE cycles later.

Structure
REQ-028 Package mega99_joy_pkg SHALL hold JOY_W=5 and bit-index constants JOY_FIRE, JOY_LEFT, JOY_RIGHT, JOY_DOWN, JOY_UP.
REQ-029 Sub-module joy_debounce_bit (synchronizer, counter, debounced flop; tick input) SHALL be instantiated 10 times; the prescaler and output and change logic live in the top.

Verification (PRESCALE=4, DEBOUNCE_SAMPLES=3)
REQ-030 Reset: hold rst_n=0 with all pins 0 -> joy1=joy2=0, joy_change=0; after release and pins held 0, joy1=5'b11111 after exactly 3 ticks plus pipeline, with one joy_change pulse.
REQ-031 Clean press: joy1_pin_n[0] 1->0 and held -> joy1[0]=1 after 2+3 ticks+1 cycles, one joy_change pulse, joy2 unchanged.
REQ-032 Glitch: joy2_pin_n[4] low for 2 ticks then high -> joy2 stays 0 and no joy_change pulse.
REQ-033 Simultaneous: joy1_pin_n[1] and joy2_pin_n[3] fall on the same cycle -> both outputs rise on the same cycle with a single joy_change pulse.
REQ-034 Enable: with joy1[2]=1, drop joy_enable -> joy1=0 next cycle with a joy_change pulse; raise it -> joy1[2]=1 again with no re-debounce delay.
REQ-035 Mid-count reset: a pin low for 2 ticks, then pulse rst_n low for 1 cycle -> all outputs 0 and the count restarts from 0, needing a full 3 ticks after release.
